// File: rtl/mem_stage_sram_pkg.sv
// Shared widths, FSM encoding and the SRAM half-word address helper
// for the memory-access pipeline stage.
package mem_stage_sram_pkg;

   localparam int SRAM_ADDR_LEN             = 18;
   localparam int SRAM_DATA_LEN             = 16;
   localparam int REGISTER_FILE_LEN         = 32;
   localparam int REGISTER_FILE_ADDRESS_LEN = 4;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_LOW  = 2'd1,
      MEM_HIGH = 2'd2,
      MEM_DONE = 2'd3
   } mem_state_e;

   // Word offset bits [18:2] select the 32-bit word; the half bit picks the 16-bit lane.
   function automatic logic [SRAM_ADDR_LEN-1:0] sram_half_addr(
      input logic [SRAM_ADDR_LEN-2:0] word_off,
      input logic                     half
   );
      return {word_off, half};
   endfunction

endpackage

// File: rtl/mem_stage_sram_sram_controller.sv
// Two-phase 16-bit SRAM access engine: FSM, wait counter, request latches,
// registered SRAM pins and low-half read capture.
module sram_controller
   import mem_stage_sram_pkg::*;
#(
   parameter int WAIT_CYCLES = 3,
   parameter int BASE_ADDR   = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mem_r_en,
   input  logic                         mem_w_en,
   input  logic [REGISTER_FILE_LEN-1:0] addr,
   input  logic [REGISTER_FILE_LEN-1:0] wdata,
   input  logic [SRAM_DATA_LEN-1:0]     sram_rdata,
   output logic [SRAM_ADDR_LEN-1:0]     sram_addr,
   output logic [SRAM_DATA_LEN-1:0]     sram_wdata,
   output logic                         sram_we_n,
   output logic [SRAM_DATA_LEN-1:0]     lo_data,
   output logic                         rd_commit,
   output logic                         ready
);

   localparam logic [3:0]                   WAIT_LAST = 4'(WAIT_CYCLES - 1);
   localparam logic [REGISTER_FILE_LEN-1:0] BASE      = REGISTER_FILE_LEN'(BASE_ADDR);

   mem_state_e                  state_reg;
   logic [3:0]                  cnt_reg;
   logic [SRAM_ADDR_LEN-2:0]    word_reg;
   logic [SRAM_DATA_LEN-1:0]    data_hi_reg;
   logic                        write_reg;
   logic                        read_reg;
   logic [SRAM_DATA_LEN-1:0]    lo_reg;
   logic [SRAM_ADDR_LEN-1:0]    sram_addr_reg;
   logic [SRAM_DATA_LEN-1:0]    sram_wdata_reg;
   logic                        sram_we_n_reg;

   logic [REGISTER_FILE_LEN-1:0] off_next;
   logic                         unused_off_bits;

   // Full 32-bit subtraction so a borrow from the ignored low bits still reaches [18:2].
   assign off_next        = addr - BASE;
   assign unused_off_bits = ^{off_next[31:19], off_next[1:0]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= MEM_IDLE;
         cnt_reg        <= '0;
         word_reg       <= '0;
         data_hi_reg    <= '0;
         write_reg      <= 1'b0;
         read_reg       <= 1'b0;
         lo_reg         <= '0;
         sram_addr_reg  <= '0;
         sram_wdata_reg <= '0;
         sram_we_n_reg  <= 1'b1;
      end else begin
         case (state_reg)
            MEM_IDLE: begin
               if (mem_r_en || mem_w_en) begin
                  state_reg      <= MEM_LOW;
                  cnt_reg        <= WAIT_LAST;
                  word_reg       <= off_next[18:2];
                  data_hi_reg    <= wdata[31:16];
                  write_reg      <= mem_w_en;
                  read_reg       <= mem_r_en & ~mem_w_en;
                  sram_addr_reg  <= sram_half_addr(off_next[18:2], 1'b0);
                  sram_we_n_reg  <= ~mem_w_en;
                  sram_wdata_reg <= mem_w_en ? wdata[15:0] : '0;
               end
            end
            MEM_LOW: begin
               if (cnt_reg == 4'd0) begin
                  state_reg      <= MEM_HIGH;
                  cnt_reg        <= WAIT_LAST;
                  sram_addr_reg  <= sram_half_addr(word_reg, 1'b1);
                  sram_wdata_reg <= write_reg ? data_hi_reg : '0;
                  if (read_reg) begin
                     lo_reg <= sram_rdata;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            MEM_HIGH: begin
               if (cnt_reg == 4'd0) begin
                  state_reg      <= MEM_DONE;
                  sram_we_n_reg  <= 1'b1;
                  sram_wdata_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            default: begin
               state_reg <= MEM_IDLE;
            end
         endcase
      end
   end

   assign sram_addr  = sram_addr_reg;
   assign sram_wdata = sram_wdata_reg;
   assign sram_we_n  = sram_we_n_reg;
   assign lo_data    = lo_reg;
   // High half is taken straight off the bus on the last HIGH cycle.
   assign rd_commit  = (state_reg == MEM_HIGH) && (cnt_reg == 4'd0) && read_reg;
   assign ready      = (state_reg == MEM_DONE);

endmodule

// File: rtl/mem_stage_sram.sv
// MEM-access pipeline stage: stalls the pipeline during SRAM accesses,
// injects bubbles while frozen and holds the last load result.
module mem_stage_sram
   import mem_stage_sram_pkg::*;
#(
   parameter int WAIT_CYCLES = 3,
   parameter int BASE_ADDR   = 1024
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 wb_en_in,
   input  logic                                 mem_r_en_in,
   input  logic                                 mem_w_en_in,
   input  logic [REGISTER_FILE_LEN-1:0]         alu_res_in,
   input  logic [REGISTER_FILE_LEN-1:0]         val_rm_in,
   input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_in,
   output logic                                 wb_en_out,
   output logic                                 mem_r_out,
   output logic [REGISTER_FILE_LEN-1:0]         alu_res_out,
   output logic [REGISTER_FILE_LEN-1:0]         mem_res_out,
   output logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_out,
   output logic                                 freeze,
   output logic [SRAM_ADDR_LEN-1:0]             sram_addr,
   output logic [SRAM_DATA_LEN-1:0]             sram_wdata,
   input  logic [SRAM_DATA_LEN-1:0]             sram_rdata,
   output logic                                 sram_we_n
);

   logic                     ready;
   logic                     rd_commit;
   logic [SRAM_DATA_LEN-1:0] lo_data;
   logic [SRAM_DATA_LEN-1:0] res_half_reg  [2];
   logic [SRAM_DATA_LEN-1:0] res_half_next [2];

   sram_controller #(
      .WAIT_CYCLES (WAIT_CYCLES),
      .BASE_ADDR   (BASE_ADDR)
   ) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .mem_r_en   (mem_r_en_in),
      .mem_w_en   (mem_w_en_in),
      .addr       (alu_res_in),
      .wdata      (val_rm_in),
      .sram_rdata (sram_rdata),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_we_n  (sram_we_n),
      .lo_data    (lo_data),
      .rd_commit  (rd_commit),
      .ready      (ready)
   );

   assign freeze      = (mem_r_en_in | mem_w_en_in) & ~ready;
   assign wb_en_out   = wb_en_in & ~freeze;
   assign mem_r_out   = mem_r_en_in & ~freeze;
   assign alu_res_out = alu_res_in;
   assign dest_out    = dest_in;

   assign res_half_next[0] = lo_data;
   assign res_half_next[1] = sram_rdata;

   // Both halves update together so a partial load is never visible.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_res_half
         always_ff @(posedge clk) begin
            if (!rst) begin
               res_half_reg[gi] <= '0;
            end else if (rd_commit) begin
               res_half_reg[gi] <= res_half_next[gi];
            end
         end
      end
   endgenerate

   assign mem_res_out = {res_half_reg[1], res_half_reg[0]};

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram: W=3 instance with a small SRAM model,
// plus a W=1 instance for address wrap below BASE_ADDR.
module tb_mem_stage_sram;

   logic clk = 1'b0;
   logic rst;
   logic preload;
   int   n_vec = 0;
   int   n_err = 0;
   int   n_frz;

   logic        wb_en_a, mem_r_a, mem_w_a;
   logic [31:0] alu_a, val_a;
   logic [3:0]  dest_a;
   logic        wb_en_out_a, mem_r_out_a, freeze_a, we_n_a;
   logic [31:0] alu_out_a, mem_res_a;
   logic [3:0]  dest_out_a;
   logic [17:0] addr_a;
   logic [15:0] wdata_a, rdata_a;
   logic [15:0] mem_a [0:63];

   logic        wb_en_b, mem_r_b, mem_w_b;
   logic [31:0] alu_b, val_b;
   logic [3:0]  dest_b;
   logic        wb_en_out_b, mem_r_out_b, freeze_b, we_n_b;
   logic [31:0] alu_out_b, mem_res_b;
   logic [3:0]  dest_out_b;
   logic [17:0] addr_b;
   logic [15:0] wdata_b, rdata_b;

   always #5 clk = ~clk;

   mem_stage_sram #(.WAIT_CYCLES(3), .BASE_ADDR(1024)) dut_a (
      .clk(clk), .rst(rst),
      .wb_en_in(wb_en_a), .mem_r_en_in(mem_r_a), .mem_w_en_in(mem_w_a),
      .alu_res_in(alu_a), .val_rm_in(val_a), .dest_in(dest_a),
      .wb_en_out(wb_en_out_a), .mem_r_out(mem_r_out_a), .alu_res_out(alu_out_a),
      .mem_res_out(mem_res_a), .dest_out(dest_out_a), .freeze(freeze_a),
      .sram_addr(addr_a), .sram_wdata(wdata_a), .sram_rdata(rdata_a), .sram_we_n(we_n_a)
   );

   mem_stage_sram #(.WAIT_CYCLES(1), .BASE_ADDR(1024)) dut_b (
      .clk(clk), .rst(rst),
      .wb_en_in(wb_en_b), .mem_r_en_in(mem_r_b), .mem_w_en_in(mem_w_b),
      .alu_res_in(alu_b), .val_rm_in(val_b), .dest_in(dest_b),
      .wb_en_out(wb_en_out_b), .mem_r_out(mem_r_out_b), .alu_res_out(alu_out_b),
      .mem_res_out(mem_res_b), .dest_out(dest_out_b), .freeze(freeze_b),
      .sram_addr(addr_b), .sram_wdata(wdata_b), .sram_rdata(rdata_b), .sram_we_n(we_n_b)
   );

   // Asynchronous-read SRAM model for instance A
   assign rdata_a = mem_a[addr_a[5:0]];
   always @(posedge clk) begin
      if (!we_n_a) begin
         mem_a[addr_a[5:0]] <= wdata_a;
      end else if (preload) begin
         mem_a[4] <= 16'h1234;
         mem_a[5] <= 16'hABCD;
      end
   end

   assign rdata_b = addr_b[15:0] ^ 16'h5A5A;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_a();
      wb_en_a = 1'b0; mem_r_a = 1'b0; mem_w_a = 1'b0;
      alu_a = '0; val_a = '0; dest_a = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      preload = 1'b1;
      idle_a();
      wb_en_b = 1'b0; mem_r_b = 1'b0; mem_w_b = 1'b0;
      alu_b = '0; val_b = '0; dest_b = '0;
      step();
      step();
      preload = 1'b0;

      chk("rst_freeze", 32'(freeze_a), 32'd0);
      chk("rst_we_n", 32'(we_n_a), 32'd1);
      chk("rst_addr", 32'(addr_a), 32'd0);
      chk("rst_wdata", 32'(wdata_a), 32'd0);
      chk("rst_mem_res", mem_res_a, 32'd0);
      chk("rst_mem_res_b", mem_res_b, 32'd0);
      rst = 1'b1;
      step();

      // Non-memory op passes straight through
      wb_en_a = 1'b1; alu_a = 32'h55; dest_a = 4'd7;
      #1;
      chk("nm_freeze", 32'(freeze_a), 32'd0);
      chk("nm_wb_en", 32'(wb_en_out_a), 32'd1);
      chk("nm_alu", alu_out_a, 32'h55);
      chk("nm_dest", 32'(dest_out_a), 32'd7);
      chk("nm_we_n", 32'(we_n_a), 32'd1);
      step();
      chk("nm_we_n2", 32'(we_n_a), 32'd1);

      // Store 0xDEADBEEF at 1024
      mem_w_a = 1'b1; alu_a = 32'd1024; val_a = 32'hDEADBEEF; dest_a = 4'd3;
      #1;
      chk("st_req_freeze", 32'(freeze_a), 32'd1);
      chk("st_req_wb_en", 32'(wb_en_out_a), 32'd0);
      chk("st_req_alu", alu_out_a, 32'd1024);
      chk("st_req_we_n", 32'(we_n_a), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_lo_addr", 32'(addr_a), 32'd0);
         chk("st_lo_wdata", 32'(wdata_a), 32'hBEEF);
         chk("st_lo_we_n", 32'(we_n_a), 32'd0);
         chk("st_lo_freeze", 32'(freeze_a), 32'd1);
         chk("st_lo_wb_en", 32'(wb_en_out_a), 32'd0);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_hi_addr", 32'(addr_a), 32'd1);
         chk("st_hi_wdata", 32'(wdata_a), 32'hDEAD);
         chk("st_hi_we_n", 32'(we_n_a), 32'd0);
         chk("st_hi_freeze", 32'(freeze_a), 32'd1);
      end
      step();
      chk("st_done_freeze", 32'(freeze_a), 32'd0);
      chk("st_done_wb_en", 32'(wb_en_out_a), 32'd1);
      chk("st_done_we_n", 32'(we_n_a), 32'd1);
      chk("st_done_wdata", 32'(wdata_a), 32'd0);
      chk("st_done_addr_hold", 32'(addr_a), 32'd1);
      idle_a();
      step();
      chk("st_mem0", 32'(mem_a[0]), 32'hBEEF);
      chk("st_mem1", 32'(mem_a[1]), 32'hDEAD);
      chk("st_mem_res", mem_res_a, 32'd0);

      // Load from 1032 -> SRAM half-words 4 and 5
      wb_en_a = 1'b1; mem_r_a = 1'b1; alu_a = 32'd1032; dest_a = 4'd5;
      #1;
      chk("ld_req_mem_r", 32'(mem_r_out_a), 32'd0);
      n_frz = 0;
      while (freeze_a && n_frz < 20) begin
         step();
         n_frz++;
         if (n_frz == 1) chk("ld_lo_addr", 32'(addr_a), 32'd4);
         if (n_frz == 4) chk("ld_hi_addr", 32'(addr_a), 32'd5);
         if (n_frz == 2) chk("ld_we_n", 32'(we_n_a), 32'd1);
      end
      chk("ld_freeze_len", 32'(n_frz), 32'd7);
      chk("ld_done_res", mem_res_a, 32'hABCD1234);
      chk("ld_done_mem_r", 32'(mem_r_out_a), 32'd1);
      chk("ld_done_wb_en", 32'(wb_en_out_a), 32'd1);
      chk("ld_done_dest", 32'(dest_out_a), 32'd5);
      idle_a();
      step();
      chk("ld_hold_res", mem_res_a, 32'hABCD1234);

      // Read and write both set: write wins, result untouched
      mem_r_a = 1'b1; mem_w_a = 1'b1; alu_a = 32'd1040; val_a = 32'h0BADF00D;
      step();
      chk("rw_we_n", 32'(we_n_a), 32'd0);
      chk("rw_addr", 32'(addr_a), 32'd8);
      for (int i = 0; i < 6; i++) step();
      chk("rw_done_freeze", 32'(freeze_a), 32'd0);
      chk("rw_done_res", mem_res_a, 32'hABCD1234);
      idle_a();
      step();
      chk("rw_mem8", 32'(mem_a[8]), 32'hF00D);
      chk("rw_mem9", 32'(mem_a[9]), 32'h0BAD);
      chk("rw_hold_res", mem_res_a, 32'hABCD1234);

      // Back-to-back loads: 1024 then 1032 with no dead cycle
      mem_r_a = 1'b1; alu_a = 32'd1024;
      for (int i = 0; i < 7; i++) step();
      chk("b2b1_freeze", 32'(freeze_a), 32'd0);
      chk("b2b1_res", mem_res_a, 32'hDEADBEEF);
      step();
      alu_a = 32'd1032;
      #1;
      chk("b2b2_req_freeze", 32'(freeze_a), 32'd1);
      step();
      chk("b2b2_lo_addr", 32'(addr_a), 32'd4);
      chk("b2b2_mid_res", mem_res_a, 32'hDEADBEEF);
      for (int i = 0; i < 6; i++) step();
      chk("b2b2_freeze", 32'(freeze_a), 32'd0);
      chk("b2b2_res", mem_res_a, 32'hABCD1234);
      idle_a();
      step();

      // Reset during the second HIGH cycle of a store to 1048
      mem_w_a = 1'b1; alu_a = 32'd1048; val_a = 32'h11112222;
      for (int i = 0; i < 5; i++) step();
      chk("rs_hi_addr", 32'(addr_a), 32'd13);
      chk("rs_hi_we_n", 32'(we_n_a), 32'd0);
      rst = 1'b0;
      step();
      chk("rs_we_n", 32'(we_n_a), 32'd1);
      chk("rs_wdata", 32'(wdata_a), 32'd0);
      chk("rs_addr", 32'(addr_a), 32'd0);
      chk("rs_mem_res", mem_res_a, 32'd0);
      chk("rs_freeze_req", 32'(freeze_a), 32'd1);
      idle_a();
      #1;
      chk("rs_freeze_idle", 32'(freeze_a), 32'd0);
      rst = 1'b1;
      step();

      // W=1 instance: load at address 0 wraps below BASE_ADDR
      mem_r_b = 1'b1; wb_en_b = 1'b1; alu_b = 32'd0;
      #1;
      chk("wr_req_freeze", 32'(freeze_b), 32'd1);
      step();
      chk("wr_lo_addr", 32'(addr_b), 32'h3FE00);
      chk("wr_lo_freeze", 32'(freeze_b), 32'd1);
      chk("wr_lo_we_n", 32'(we_n_b), 32'd1);
      step();
      chk("wr_hi_addr", 32'(addr_b), 32'h3FE01);
      chk("wr_hi_freeze", 32'(freeze_b), 32'd1);
      step();
      chk("wr_done_freeze", 32'(freeze_b), 32'd0);
      chk("wr_done_res", mem_res_b, 32'hA45BA45A);
      chk("wr_done_mem_r", 32'(mem_r_out_b), 32'd1);
      mem_r_b = 1'b0; wb_en_b = 1'b0;
      step();
      chk("wr_hold_res", mem_res_b, 32'hA45BA45A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
